// File: rtl/exp_alu_stage_if.sv
// Exponent-stage bundle: micro-op handshake, register-file read/write paths and status flags.
// The stage connects through the slave modport; the sequencer/register-file side uses master.
interface exp_alu_stage_if #(
  parameter int REGISTER_WIDTH = 9
);
  logic                      uopValid_in;
  logic                      uopReady_out;
  logic [2:0]                uopOp_in;
  logic [2:0]                uopSelA_in;
  logic [2:0]                uopSelB_in;
  logic [1:0]                uopDest_in;
  logic [2:0]                readSelectA_out;
  logic [2:0]                readSelectB_out;
  logic [REGISTER_WIDTH-1:0] readResultA_in;
  logic [REGISTER_WIDTH-1:0] readResultB_in;
  logic                      writeEnableR0_out;
  logic                      writeEnableR1_out;
  logic [REGISTER_WIDTH-1:0] writeValueR0_out;
  logic [REGISTER_WIDTH-1:0] writeValueR1_out;
  logic                      resultValid_out;
  logic                      flagZero_out;
  logic                      flagNeg_out;
  logic                      flagCarry_out;
  logic                      busy_out;

  modport slave (
    input  uopValid_in, uopOp_in, uopSelA_in, uopSelB_in, uopDest_in,
    input  readResultA_in, readResultB_in,
    output uopReady_out, readSelectA_out, readSelectB_out,
    output writeEnableR0_out, writeEnableR1_out, writeValueR0_out, writeValueR1_out,
    output resultValid_out, flagZero_out, flagNeg_out, flagCarry_out, busy_out
  );

  modport master (
    output uopValid_in, uopOp_in, uopSelA_in, uopSelB_in, uopDest_in,
    output readResultA_in, readResultB_in,
    input  uopReady_out, readSelectA_out, readSelectB_out,
    input  writeEnableR0_out, writeEnableR1_out, writeValueR0_out, writeValueR1_out,
    input  resultValid_out, flagZero_out, flagNeg_out, flagCarry_out, busy_out
  );
endinterface

// File: rtl/exp_alu_stage.sv
// Exponent-path execution stage: E1 latches operands, E2 registers the result, writeback and flags.
// A read-after-write interlock holds off micro-ops that read R0/R1 while a write to it is in flight.
module exp_alu_stage #(
  parameter int REGISTER_WIDTH = 9
) (
  input  logic           clk_in,
  input  logic           reset_n_in,
  exp_alu_stage_if.slave bus
);
  localparam int W = REGISTER_WIDTH;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_PASS = 3'b010;
  localparam logic [2:0] OP_MAX  = 3'b011;
  localparam logic [2:0] OP_CMP  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;

  localparam logic [W:0] ONE_EXT = {{W{1'b0}}, 1'b1};

  logic         e1_valid_q;
  logic [2:0]   e1_op_q;
  logic [1:0]   e1_wr_q;
  logic [W-1:0] e1_a_q;
  logic [W-1:0] e1_b_q;

  logic         rv_q;
  logic         we0_q;
  logic         we1_q;
  logic [W-1:0] val_q;
  logic         zero_q;
  logic         neg_q;
  logic         carry_q;

  logic         op_writes;
  logic         accept;
  logic         pend_r0;
  logic         pend_r1;
  logic         hit_r0;
  logic         hit_r1;
  logic         e1_is_nop;
  logic [W:0]   a_ext;
  logic [W:0]   b_ext;
  logic [W:0]   res_d;
  logic         carry_d;

  // Only ops that really write a register count as hazards (CMP and NOP never write).
  assign op_writes = (bus.uopOp_in != OP_CMP) && (bus.uopOp_in[2:1] != 2'b11);
  assign pend_r0   = (e1_valid_q && e1_wr_q[0]) || we0_q;
  assign pend_r1   = (e1_valid_q && e1_wr_q[1]) || we1_q;
  assign hit_r0    = (bus.uopSelA_in == 3'b000) || (bus.uopSelB_in == 3'b000);
  assign hit_r1    = (bus.uopSelA_in == 3'b001) || (bus.uopSelB_in == 3'b001);

  assign bus.uopReady_out    = !((pend_r0 && hit_r0) || (pend_r1 && hit_r1));
  assign accept              = bus.uopValid_in && bus.uopReady_out;
  assign bus.readSelectA_out = bus.uopSelA_in;
  assign bus.readSelectB_out = bus.uopSelB_in;

  assign e1_is_nop = (e1_op_q[2:1] == 2'b11);
  assign a_ext     = {1'b0, e1_a_q};
  assign b_ext     = {1'b0, e1_b_q};

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (e1_op_q)
      OP_ADD: begin
        res_d   = a_ext + b_ext;
        carry_d = res_d[W];
      end
      OP_SUB, OP_CMP: begin
        res_d   = a_ext - b_ext;
        carry_d = res_d[W];
      end
      OP_PASS: res_d = a_ext;
      OP_MAX: begin
        carry_d = (e1_a_q < e1_b_q);
        res_d   = carry_d ? b_ext : a_ext;
      end
      OP_INC: begin
        res_d   = a_ext + ONE_EXT;
        carry_d = res_d[W];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      e1_valid_q <= 1'b0;
      e1_op_q    <= '0;
      e1_wr_q    <= '0;
      e1_a_q     <= '0;
      e1_b_q     <= '0;
      rv_q       <= 1'b0;
      we0_q      <= 1'b0;
      we1_q      <= 1'b0;
      val_q      <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      e1_valid_q <= accept;
      if (accept) begin
        e1_op_q <= bus.uopOp_in;
        e1_wr_q <= op_writes ? bus.uopDest_in : 2'b00;
        e1_a_q  <= bus.readResultA_in;
        e1_b_q  <= bus.readResultB_in;
      end
      rv_q  <= e1_valid_q;
      we0_q <= e1_valid_q && e1_wr_q[0];
      we1_q <= e1_valid_q && e1_wr_q[1];
      if (e1_valid_q && (e1_wr_q != 2'b00)) begin
        val_q <= res_d[W-1:0];
      end
      // Flags are sticky across NOPs and idle cycles.
      if (e1_valid_q && !e1_is_nop) begin
        zero_q  <= (res_d[W-1:0] == '0);
        neg_q   <= res_d[W-1];
        carry_q <= carry_d;
      end
    end
  end

  assign bus.writeEnableR0_out = we0_q;
  assign bus.writeEnableR1_out = we1_q;
  assign bus.writeValueR0_out  = val_q;
  assign bus.writeValueR1_out  = val_q;
  assign bus.resultValid_out   = rv_q;
  assign bus.flagZero_out      = zero_q;
  assign bus.flagNeg_out       = neg_q;
  assign bus.flagCarry_out     = carry_q;
  assign bus.busy_out          = e1_valid_q || rv_q;
endmodule

// File: tb/tb_exp_alu_stage.sv
// Bench for exp_alu_stage: register-file model, in-order architectural reference model,
// directed scenarios with literal expectations, then randomized micro-op traffic with resets.
module tb_exp_alu_stage;
  logic clk;
  logic rst_n;

  exp_alu_stage_if #(.REGISTER_WIDTH(9)) bus ();

  exp_alu_stage #(.REGISTER_WIDTH(9)) dut (
    .clk_in    (clk),
    .reset_n_in(rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int kval(input int sel);
    case (sel)
      2: return 0;
      3: return 1;
      4: return 31;
      5: return 63;
      6: return 127;
      default: return 511;
    endcase
  endfunction

  // Register file around the stage; starts dirty and is not touched by reset.
  logic [8:0] rf_r0 = 9'd5;
  logic [8:0] rf_r1 = 9'd200;

  always_ff @(posedge clk) begin
    if (bus.writeEnableR0_out) rf_r0 <= bus.writeValueR0_out;
    if (bus.writeEnableR1_out) rf_r1 <= bus.writeValueR1_out;
  end

  always_comb begin
    case (bus.readSelectA_out)
      3'd0:    bus.readResultA_in = rf_r0;
      3'd1:    bus.readResultA_in = rf_r1;
      default: bus.readResultA_in = 9'(kval(int'(bus.readSelectA_out)));
    endcase
    case (bus.readSelectB_out)
      3'd0:    bus.readResultB_in = rf_r0;
      3'd1:    bus.readResultB_in = rf_r1;
      default: bus.readResultB_in = 9'(kval(int'(bus.readSelectB_out)));
    endcase
  end

  // Reference model: ops execute in program order at acceptance; outputs appear two cycles later.
  typedef struct {
    int due;
    bit we0;
    bit we1;
    int val;
    bit upd;
    bit z;
    bit n;
    bit c;
  } exp_t;

  exp_t q[$];
  int   m_r0 = 5;
  int   m_r1 = 200;
  int   c_r0 = 5;
  int   c_r1 = 200;
  bit   m_z, m_n, m_c;

  function automatic void model_op(input int op, input int a, input int b,
                                   output int res, output bit carry);
    res   = 0;
    carry = 0;
    case (op)
      0: begin res = (a + b) % 512; carry = (a + b) > 511; end
      1, 4: begin res = (a - b + 512) % 512; carry = a < b; end
      2: res = a;
      3: begin res = (a >= b) ? a : b; carry = a < b; end
      5: begin res = (a + 1) % 512; carry = (a + 1) > 511; end
      default: ;
    endcase
  endfunction

  function automatic int mread(input int sel);
    if (sel == 0) return m_r0;
    if (sel == 1) return m_r1;
    return kval(sel);
  endfunction

  initial begin : compare_proc
    int   cyc;
    bit   pend0, pend1, rdy_e, rv_e, we0_e, we1_e;
    int   val_e, sa, sb, op, res;
    bit   carry;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rv", bus.resultValid_out, 0);
        chk("rst_we0", bus.writeEnableR0_out, 0);
        chk("rst_we1", bus.writeEnableR1_out, 0);
        chk("rst_val0", bus.writeValueR0_out, 0);
        chk("rst_val1", bus.writeValueR1_out, 0);
        chk("rst_zero", bus.flagZero_out, 0);
        chk("rst_neg", bus.flagNeg_out, 0);
        chk("rst_carry", bus.flagCarry_out, 0);
        chk("rst_busy", bus.busy_out, 0);
        chk("rst_ready", bus.uopReady_out, 1);
        q.delete();
        m_r0 = c_r0;
        m_r1 = c_r1;
        m_z  = 0;
        m_n  = 0;
        m_c  = 0;
      end else begin
        pend0 = 0;
        pend1 = 0;
        foreach (q[i]) begin
          pend0 |= q[i].we0;
          pend1 |= q[i].we1;
        end
        sa    = int'(bus.uopSelA_in);
        sb    = int'(bus.uopSelB_in);
        rdy_e = !((pend0 && (sa == 0 || sb == 0)) || (pend1 && (sa == 1 || sb == 1)));
        chk("ready", bus.uopReady_out, rdy_e);
        chk("busy", bus.busy_out, q.size() != 0);
        chk("rdselA", bus.readSelectA_out, sa);
        chk("rdselB", bus.readSelectB_out, sb);

        rv_e  = 0;
        we0_e = 0;
        we1_e = 0;
        val_e = 0;
        if (q.size() != 0 && q[0].due == cyc) begin
          e     = q.pop_front();
          rv_e  = 1;
          we0_e = e.we0;
          we1_e = e.we1;
          val_e = e.val;
          if (e.upd) begin
            m_z = e.z;
            m_n = e.n;
            m_c = e.c;
          end
          if (e.we0) c_r0 = e.val;
          if (e.we1) c_r1 = e.val;
        end
        chk("result_valid", bus.resultValid_out, rv_e);
        chk("we0", bus.writeEnableR0_out, we0_e);
        chk("we1", bus.writeEnableR1_out, we1_e);
        if (we0_e || we1_e) begin
          chk("val0", bus.writeValueR0_out, val_e);
          chk("val1", bus.writeValueR1_out, val_e);
        end
        chk("zero", bus.flagZero_out, m_z);
        chk("neg", bus.flagNeg_out, m_n);
        chk("carry", bus.flagCarry_out, m_c);

        if (bus.uopValid_in && rdy_e) begin
          op = int'(bus.uopOp_in);
          model_op(op, mread(sa), mread(sb), res, carry);
          e.due = cyc + 2;
          e.upd = (op < 6);
          e.we0 = (op < 6) && (op != 4) && bus.uopDest_in[0];
          e.we1 = (op < 6) && (op != 4) && bus.uopDest_in[1];
          e.val = res;
          e.z   = (res == 0);
          e.n   = (res >= 256);
          e.c   = carry;
          if (e.we0) m_r0 = res;
          if (e.we1) m_r1 = res;
          q.push_back(e);
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int op, input int a, input int b, input int d);
    bus.uopValid_in = v;
    bus.uopOp_in    = 3'(op);
    bus.uopSelA_in  = 3'(a);
    bus.uopSelB_in  = 3'(b);
    bus.uopDest_in  = 2'(d);
  endtask

  task automatic drive_idle();
    drive(0, 7, 2, 2, 0);
  endtask

  initial begin : stim_proc
    bit v;
    int op, sa, sb, d, hold_cnt;
    bit holding;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) tick();
    rst_n = 1'b1;
    at_neg();
    chk("ready_after_rst", bus.uopReady_out, 1);
    chk("busy_after_rst", bus.busy_out, 0);
    tick();

    // ADD R0 = 127 + 31, write appears two cycles after acceptance only
    drive(1, 0, 6, 4, 1);
    at_neg(); chk("d2_ready", bus.uopReady_out, 1);
    tick(); drive_idle();
    at_neg(); chk("d2_we0_n1", bus.writeEnableR0_out, 0);
    tick();
    at_neg();
    chk("d2_we0_n2", bus.writeEnableR0_out, 1);
    chk("d2_val", bus.writeValueR0_out, 158);
    chk("d2_zero", bus.flagZero_out, 0);
    chk("d2_carry", bus.flagCarry_out, 0);
    tick();
    at_neg(); chk("d2_we0_n3", bus.writeEnableR0_out, 0);
    tick();

    // Dependent SUB R1 = R0 - 127 stalls two cycles
    drive(1, 0, 6, 4, 1);
    at_neg(); tick();
    drive(1, 1, 0, 6, 2);
    at_neg(); chk("d3_ready_n1", bus.uopReady_out, 0);
    tick();
    at_neg(); chk("d3_ready_n2", bus.uopReady_out, 0);
    tick();
    at_neg(); chk("d3_ready_n3", bus.uopReady_out, 1);
    tick(); drive_idle();
    at_neg(); chk("d3_we1_n4", bus.writeEnableR1_out, 0);
    tick();
    at_neg();
    chk("d3_we1_n5", bus.writeEnableR1_out, 1);
    chk("d3_val1", bus.writeValueR1_out, 31);
    chk("d3_we0_n5", bus.writeEnableR0_out, 0);
    tick();

    // 511 + 1 into both registers wraps to zero
    drive(1, 0, 7, 3, 3);
    at_neg(); tick(); drive_idle();
    at_neg(); tick();
    at_neg();
    chk("d4_we0", bus.writeEnableR0_out, 1);
    chk("d4_we1", bus.writeEnableR1_out, 1);
    chk("d4_val", bus.writeValueR0_out, 0);
    chk("d4_zero", bus.flagZero_out, 1);
    chk("d4_carry", bus.flagCarry_out, 1);
    chk("d4_neg", bus.flagNeg_out, 0);
    tick();

    // CMP 31 vs 127, then NOP keeps flags
    drive(1, 4, 4, 6, 3);
    at_neg(); tick();
    drive(1, 6, 2, 2, 0);
    at_neg(); tick(); drive_idle();
    at_neg();
    chk("d5_rv", bus.resultValid_out, 1);
    chk("d5_we0", bus.writeEnableR0_out, 0);
    chk("d5_we1", bus.writeEnableR1_out, 0);
    chk("d5_carry", bus.flagCarry_out, 1);
    chk("d5_neg", bus.flagNeg_out, 1);
    chk("d5_zero", bus.flagZero_out, 0);
    tick();
    at_neg();
    chk("d5_nop_rv", bus.resultValid_out, 1);
    chk("d5_nop_carry", bus.flagCarry_out, 1);
    chk("d5_nop_neg", bus.flagNeg_out, 1);
    tick();
    at_neg(); chk("d5_idle_rv", bus.resultValid_out, 0);
    tick();

    // Independent back-to-back ops do not stall
    drive(1, 0, 6, 4, 1);
    at_neg(); tick();
    drive(1, 5, 4, 2, 2);
    at_neg(); chk("d6_ready", bus.uopReady_out, 1);
    tick(); drive_idle();
    at_neg();
    chk("d6_we0", bus.writeEnableR0_out, 1);
    chk("d6_val0", bus.writeValueR0_out, 158);
    chk("d6_we1_early", bus.writeEnableR1_out, 0);
    tick();
    at_neg();
    chk("d6_we1", bus.writeEnableR1_out, 1);
    chk("d6_val1", bus.writeValueR1_out, 32);
    chk("d6_we0_late", bus.writeEnableR0_out, 0);
    tick();

    // Reset while an op sits in E1 discards it
    drive(1, 0, 6, 4, 1);
    at_neg(); tick();
    rst_n = 1'b0;
    drive_idle();
    at_neg();
    chk("d7_busy", bus.busy_out, 0);
    chk("d7_we0", bus.writeEnableR0_out, 0);
    tick();
    rst_n = 1'b1;
    at_neg(); chk("d7_we0_after", bus.writeEnableR0_out, 0);
    tick();
    at_neg(); chk("d7_we0_after2", bus.writeEnableR0_out, 0);
    tick();

    // Randomized traffic, biased towards R0/R1 selects to exercise the interlock
    holding  = 0;
    hold_cnt = 0;
    v = 0; op = 7; sa = 2; sb = 2; d = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!holding) begin
        v  = ($urandom_range(0, 9) < 7);
        op = $urandom_range(0, 7);
        sa = $urandom_range(0, 1) ? $urandom_range(0, 1) : $urandom_range(2, 7);
        sb = $urandom_range(0, 1) ? $urandom_range(0, 1) : $urandom_range(2, 7);
        d  = $urandom_range(0, 3);
        hold_cnt = 0;
      end
      drive(v, op, sa, sb, d);
      at_neg();
      holding = v && !bus.uopReady_out;
      if (holding) hold_cnt++;
      if (hold_cnt >= 8) begin
        n_checks++;
        n_err++;
        $display("FAIL stall_bound at %0t: stalled %0d cycles, expected at most 2", $time, hold_cnt);
        holding = 0;
      end
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        drive_idle();
        holding = 0;
        at_neg();
        tick();
        rst_n = 1'b1;
      end
    end
    drive_idle();
    repeat (4) tick();
    at_neg();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end
endmodule
